// File: rtl/id_ex_stage_if.sv
// Signal bundle between ID, the forwarding sources and the ID/EX stage.
// The master side drives ID fields and forward sources; the slave is the stage itself.
interface id_ex_stage_if;
  logic        hold_in;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [4:0]  id_rd;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic [31:0] id_imm;
  logic [4:0]  id_shamt;
  logic [4:0]  id_aluop;
  logic        id_asel_shamt;
  logic        id_bsel_imm;
  logic        id_regwrite;
  logic        id_memread;
  logic        id_memwrite;
  logic        id_memtoreg;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_valid;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_memtoreg;
  logic        stall;

  modport master (
    output hold_in, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_rs_val, id_rt_val, id_imm, id_shamt, id_aluop, id_asel_shamt, id_bsel_imm,
           id_regwrite, id_memread, id_memwrite, id_memtoreg,
           exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
    input  alu_a, alu_b, alu_op, ex_store_data, ex_rd, ex_valid, ex_regwrite,
           ex_memread, ex_memwrite, ex_memtoreg, stall
  );

  modport slave (
    input  hold_in, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_rs_val, id_rt_val, id_imm, id_shamt, id_aluop, id_asel_shamt, id_bsel_imm,
           id_regwrite, id_memread, id_memwrite, id_memtoreg,
           exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
    output alu_a, alu_b, alu_op, ex_store_data, ex_rd, ex_valid, ex_regwrite,
           ex_memread, ex_memwrite, ex_memtoreg, stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX/MEM and MEM/WB
// operand forwarding, and ALU A/B operand selection.
module id_ex_stage (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  logic        valid_q;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [4:0]  rd_q;
  logic [31:0] rs_val_q;
  logic [31:0] rt_val_q;
  logic [31:0] imm_q;
  logic [4:0]  shamt_q;
  logic [4:0]  aluop_q;
  logic        asel_shamt_q;
  logic        bsel_imm_q;
  logic        regwrite_q;
  logic        memread_q;
  logic        memwrite_q;
  logic        memtoreg_q;

  logic        load_use;
  logic        rs_hit;
  logic        rt_hit;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  // A load in EX cannot supply its data to the instruction right behind it.
  assign rs_hit   = bus.id_uses_rs && (bus.id_rs == rd_q);
  assign rt_hit   = bus.id_uses_rt && (bus.id_rt == rd_q);
  assign load_use = valid_q && memread_q && (rd_q != 5'd0) && bus.id_valid && (rs_hit || rt_hit);

  assign bus.stall = load_use || bus.hold_in;

  always_ff @(posedge clk) begin
    if (rst || (!bus.hold_in && (bus.flush || load_use))) begin
      valid_q      <= 1'b0;
      rs_q         <= 5'd0;
      rt_q         <= 5'd0;
      rd_q         <= 5'd0;
      rs_val_q     <= 32'd0;
      rt_val_q     <= 32'd0;
      imm_q        <= 32'd0;
      shamt_q      <= 5'd0;
      aluop_q      <= 5'd0;
      asel_shamt_q <= 1'b0;
      bsel_imm_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
    end else if (!bus.hold_in) begin
      valid_q      <= bus.id_valid;
      rs_q         <= bus.id_rs;
      rt_q         <= bus.id_rt;
      rd_q         <= bus.id_rd;
      rs_val_q     <= bus.id_rs_val;
      rt_val_q     <= bus.id_rt_val;
      imm_q        <= bus.id_imm;
      shamt_q      <= bus.id_shamt;
      aluop_q      <= bus.id_aluop;
      asel_shamt_q <= bus.id_asel_shamt;
      bsel_imm_q   <= bus.id_bsel_imm;
      regwrite_q   <= bus.id_valid && bus.id_regwrite;
      memread_q    <= bus.id_valid && bus.id_memread;
      memwrite_q   <= bus.id_valid && bus.id_memwrite;
      memtoreg_q   <= bus.id_valid && bus.id_memtoreg;
    end
  end

  // r0 is hardwired, so a stray write to it downstream must never be forwarded.
  always_comb begin
    fwd_rs = rs_val_q;
    fwd_rt = rt_val_q;
    if (rs_q != 5'd0) begin
      if (bus.exmem_regwrite && (bus.exmem_rd == rs_q))
        fwd_rs = bus.exmem_result;
      else if (bus.memwb_regwrite && (bus.memwb_rd == rs_q))
        fwd_rs = bus.memwb_result;
    end
    if (rt_q != 5'd0) begin
      if (bus.exmem_regwrite && (bus.exmem_rd == rt_q))
        fwd_rt = bus.exmem_result;
      else if (bus.memwb_regwrite && (bus.memwb_rd == rt_q))
        fwd_rt = bus.memwb_result;
    end
  end

  assign bus.alu_a         = asel_shamt_q ? {27'd0, shamt_q} : fwd_rs;
  assign bus.alu_b         = bsel_imm_q ? imm_q : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
  assign bus.alu_op        = aluop_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_regwrite   = regwrite_q;
  assign bus.ex_memread    = memread_q;
  assign bus.ex_memwrite   = memwrite_q;
  assign bus.ex_memtoreg   = memtoreg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a per-cycle model check plus directed
// vectors with hand-computed expectations.
module tb_id_ex_stage;

  logic clk;
  logic rst;
  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rsv;
    logic [31:0] rtv;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  aluop;
    logic        asel;
    logic        bsel;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        mt;
  } ex_model_t;

  ex_model_t m;
  bit known = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Value of a register as the EX instruction must see it: newest in-flight writer wins.
  function automatic logic [31:0] newestValue(input logic [4:0] idx, input logic [31:0] regval);
    if (idx == 5'd0) return regval;
    if (bus.exmem_regwrite && bus.exmem_rd == idx) return bus.exmem_result;
    if (bus.memwb_regwrite && bus.memwb_rd == idx) return bus.memwb_result;
    return regval;
  endfunction

  function automatic bit loadUseExpected();
    if (!(m.valid && m.mr && m.rd != 5'd0 && bus.id_valid)) return 0;
    return (bus.id_uses_rs && bus.id_rs == m.rd) || (bus.id_uses_rt && bus.id_rt == m.rd);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m = '0;
      known = 1;
    end else if (bus.hold_in) begin
      m = m;
    end else if (bus.flush || loadUseExpected()) begin
      m = '0;
    end else begin
      m.valid = bus.id_valid;
      m.rs    = bus.id_rs;
      m.rt    = bus.id_rt;
      m.rd    = bus.id_rd;
      m.rsv   = bus.id_rs_val;
      m.rtv   = bus.id_rt_val;
      m.imm   = bus.id_imm;
      m.shamt = bus.id_shamt;
      m.aluop = bus.id_aluop;
      m.asel  = bus.id_asel_shamt;
      m.bsel  = bus.id_bsel_imm;
      m.rw    = bus.id_valid && bus.id_regwrite;
      m.mr    = bus.id_valid && bus.id_memread;
      m.mw    = bus.id_valid && bus.id_memwrite;
      m.mt    = bus.id_valid && bus.id_memtoreg;
    end
  end

  always @(negedge clk) begin
    if (known) begin
      checkOutput("model alu_a", bus.alu_a, m.asel ? {27'd0, m.shamt} : newestValue(m.rs, m.rsv));
      checkOutput("model alu_b", bus.alu_b, m.bsel ? m.imm : newestValue(m.rt, m.rtv));
      checkOutput("model store", bus.ex_store_data, newestValue(m.rt, m.rtv));
      checkOutput("model alu_op", {27'd0, bus.alu_op}, {27'd0, m.aluop});
      checkOutput("model ex_rd", {27'd0, bus.ex_rd}, {27'd0, m.rd});
      checkOutput("model ctrl",
                  {27'd0, bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg},
                  {27'd0, m.valid, m.rw, m.mr, m.mw, m.mt});
      checkOutput("model stall", {31'd0, bus.stall}, {31'd0, loadUseExpected() || bus.hold_in});
    end
  end

  task automatic applyStimulus();
    @(negedge clk);
    #1;
  endtask

  task automatic clearId();
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.id_rd = 0; bus.id_rs_val = 0; bus.id_rt_val = 0; bus.id_imm = 0; bus.id_shamt = 0;
    bus.id_aluop = 0; bus.id_asel_shamt = 0; bus.id_bsel_imm = 0; bus.id_regwrite = 0;
    bus.id_memread = 0; bus.id_memwrite = 0; bus.id_memtoreg = 0;
  endtask

  task automatic clearFwd();
    bus.exmem_regwrite = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_regwrite = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
  endtask

  task automatic loadWord8();
    clearId();
    bus.id_valid = 1; bus.id_rs = 5'd1; bus.id_uses_rs = 1; bus.id_rs_val = 32'h100;
    bus.id_rd = 5'd8; bus.id_imm = 32'd4; bus.id_bsel_imm = 1; bus.id_aluop = 5'd1;
    bus.id_memread = 1; bus.id_regwrite = 1; bus.id_memtoreg = 1;
  endtask

  task automatic addReading8();
    clearId();
    bus.id_valid = 1; bus.id_rs = 5'd3; bus.id_uses_rs = 1; bus.id_rs_val = 32'd2;
    bus.id_rt = 5'd8; bus.id_uses_rt = 1; bus.id_rt_val = 32'd0; bus.id_rd = 5'd10;
    bus.id_aluop = 5'd1; bus.id_regwrite = 1;
  endtask

  initial begin
    rst = 1;
    bus.hold_in = 0;
    bus.flush = 0;
    clearFwd();
    clearId();
    bus.id_valid = 1; bus.id_rs = 5'd4; bus.id_rd = 5'd7; bus.id_aluop = 5'd9;
    bus.id_regwrite = 1; bus.id_memread = 1; bus.id_memwrite = 1; bus.id_memtoreg = 1;
    applyStimulus();
    checkOutput("reset ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("reset ex_ctrl", {28'd0, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg}, 32'd0);
    checkOutput("reset ex_rd", {27'd0, bus.ex_rd}, 32'd0);
    checkOutput("reset alu_op", {27'd0, bus.alu_op}, 32'd0);
    checkOutput("reset stall", {31'd0, bus.stall}, 32'd0);
    rst = 0;

    // EX/MEM beats MEM/WB, MEM/WB beats the register file
    clearId();
    bus.id_valid = 1; bus.id_rs = 5'd5; bus.id_uses_rs = 1; bus.id_rs_val = 32'd1;
    bus.id_rt = 5'd6; bus.id_uses_rt = 1; bus.id_rt_val = 32'd7; bus.id_rd = 5'd9;
    bus.id_aluop = 5'd1; bus.id_regwrite = 1;
    applyStimulus();
    bus.exmem_regwrite = 1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'h10;
    bus.memwb_regwrite = 1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'h20;
    #1 checkOutput("fwd exmem prio", bus.alu_a, 32'h10);
    checkOutput("add alu_op", {27'd0, bus.alu_op}, 32'd1);
    checkOutput("add ex_rd", {27'd0, bus.ex_rd}, 32'd9);
    bus.exmem_regwrite = 0;
    #1 checkOutput("fwd memwb", bus.alu_a, 32'h20);
    bus.memwb_regwrite = 0;
    #1 checkOutput("no fwd", bus.alu_a, 32'd1);
    checkOutput("alu_b regfile", bus.alu_b, 32'd7);

    // r0 guard
    clearId();
    bus.id_valid = 1; bus.id_uses_rs = 1; bus.id_aluop = 5'd1;
    applyStimulus();
    bus.exmem_regwrite = 1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'hFFFF;
    #1 checkOutput("r0 guard alu_a", bus.alu_a, 32'd0);
    checkOutput("r0 guard alu_b", bus.alu_b, 32'd0);
    clearFwd();

    // load-use: one bubble, then MEM/WB forwarding
    loadWord8();
    applyStimulus();
    addReading8();
    #1 checkOutput("lu ex_memread", {31'd0, bus.ex_memread}, 32'd1);
    checkOutput("lu stall", {31'd0, bus.stall}, 32'd1);
    applyStimulus();
    checkOutput("lu bubble valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("lu bubble op", {27'd0, bus.alu_op}, 32'd0);
    checkOutput("lu stall drop", {31'd0, bus.stall}, 32'd0);
    bus.exmem_regwrite = 1; bus.exmem_rd = 5'd8; bus.exmem_result = 32'h104;
    applyStimulus();
    bus.exmem_regwrite = 0;
    bus.memwb_regwrite = 1; bus.memwb_rd = 5'd8; bus.memwb_result = 32'h1234;
    #1 checkOutput("lu alu_b", bus.alu_b, 32'h1234);
    checkOutput("lu alu_a", bus.alu_a, 32'd2);
    checkOutput("lu ex_rd", {27'd0, bus.ex_rd}, 32'd10);
    checkOutput("lu valid", {31'd0, bus.ex_valid}, 32'd1);
    clearFwd();

    // shamt and immediate operand selection
    clearId();
    bus.id_valid = 1; bus.id_rt = 5'd2; bus.id_uses_rt = 1; bus.id_rt_val = 32'h5;
    bus.id_shamt = 5'd3; bus.id_asel_shamt = 1; bus.id_aluop = 5'd8; bus.id_rd = 5'd4;
    bus.id_regwrite = 1; bus.id_rs_val = 32'hDEAD;
    applyStimulus();
    #1 checkOutput("sll alu_a", bus.alu_a, 32'd3);
    checkOutput("sll alu_b", bus.alu_b, 32'd5);
    checkOutput("sll alu_op", {27'd0, bus.alu_op}, 32'd8);
    clearId();
    bus.id_valid = 1; bus.id_rs = 5'd2; bus.id_uses_rs = 1; bus.id_rs_val = 32'h5;
    bus.id_rt = 5'd7; bus.id_uses_rt = 1; bus.id_rt_val = 32'h77; bus.id_imm = 32'hFFFF_FFFC;
    bus.id_bsel_imm = 1; bus.id_memwrite = 1; bus.id_aluop = 5'd1;
    applyStimulus();
    bus.memwb_regwrite = 1; bus.memwb_rd = 5'd7; bus.memwb_result = 32'hABCD;
    #1 checkOutput("imm alu_b", bus.alu_b, 32'hFFFF_FFFC);
    checkOutput("store fwd", bus.ex_store_data, 32'hABCD);
    checkOutput("imm alu_a", bus.alu_a, 32'h5);
    checkOutput("sw memwrite", {31'd0, bus.ex_memwrite}, 32'd1);
    clearFwd();

    // flush squashes a valid instruction
    clearId();
    bus.id_valid = 1; bus.id_rd = 5'd11; bus.id_regwrite = 1; bus.id_aluop = 5'd2;
    bus.flush = 1;
    applyStimulus();
    bus.flush = 0;
    checkOutput("flush valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("flush regwrite", {31'd0, bus.ex_regwrite}, 32'd0);

    // hold freezes EX contents and beats a simultaneous flush
    clearId();
    bus.id_valid = 1; bus.id_rd = 5'd12; bus.id_regwrite = 1; bus.id_aluop = 5'd3;
    applyStimulus();
    checkOutput("pre-hold ex_rd", {27'd0, bus.ex_rd}, 32'd12);
    for (int i = 0; i < 3; i++) begin
      bus.hold_in = 1;
      bus.flush = (i == 1);
      bus.id_rd = 5'(20 + i);
      bus.id_aluop = 5'(10 + i);
      bus.id_valid = (i != 2);
      #1 checkOutput("hold stall", {31'd0, bus.stall}, 32'd1);
      applyStimulus();
      checkOutput("hold ex_rd", {27'd0, bus.ex_rd}, 32'd12);
      checkOutput("hold alu_op", {27'd0, bus.alu_op}, 32'd3);
      checkOutput("hold valid", {31'd0, bus.ex_valid}, 32'd1);
    end
    bus.hold_in = 0;
    bus.flush = 0;
    bus.id_valid = 1;
    applyStimulus();
    checkOutput("release ex_rd", {27'd0, bus.ex_rd}, 32'd22);

    // reset during a load-use stall empties the stage
    loadWord8();
    applyStimulus();
    addReading8();
    #1 checkOutput("rst-stall stall", {31'd0, bus.stall}, 32'd1);
    rst = 1;
    applyStimulus();
    rst = 0;
    checkOutput("rst-stall valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("rst-stall drop", {31'd0, bus.stall}, 32'd0);
    applyStimulus();
    applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage pipeline, sitting directly upstream of the EX-stage ALU. It registers decoded operands and control from ID. It detects load-use hazards and inserts bubbles. It resolves operand forwarding from EX/MEM and MEM/WB, then selects the ALU's A/B inputs (register, shamt or immediate) and drives A, B and ALUOp into the ALU.

## Interface
Parameters:
- none (widths fixed: 32-bit data, 5-bit register index, 5-bit ALUOp)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- hold_in  in  1  downstream freeze (memory wait); stage holds its contents
- flush  in  1  branch/jump squash; the next EX contents become a bubble
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5 each  source register indices
- id_uses_rs, id_uses_rt  in  1 each  instruction reads rs / rt
- id_rd  in  5  destination register (already muxed rd/rt/31)
- id_rs_val, id_rt_val  in  32 each  register-file read data
- id_imm  in  32  extended immediate
- id_shamt  in  5  shift amount field
- id_aluop  in  5  ALU operation code
- id_asel_shamt  in  1  A := zero-extended shamt, else forwarded rs
- id_bsel_imm  in  1  B := imm, else forwarded rt
- id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  control
- exmem_regwrite  in  1; exmem_rd  in  5; exmem_result  in  32  EX/MEM forward source
- memwb_regwrite  in  1; memwb_rd  in  5; memwb_result  in  32  MEM/WB forward source
- alu_a, alu_b  out  32 each  ALU operands
- alu_op  out  5  registered ALUOp
- ex_store_data  out  32  forwarded rt value for stores
- ex_rd  out  5; ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1 each
- stall  out  1  freeze PC and IF/ID (= load_use | hold_in)

## Operation
- Registered fields: valid, rs, rt, rd, rs_val, rt_val, imm, shamt, aluop, asel_shamt, bsel_imm, regwrite, memread, memwrite, memtoreg.
- load_use (combinational) = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
- Edge update priority: rst > hold_in (keep all) > (flush | load_use) → bubble > capture ID fields.
- Bubble: every registered field cleared to 0 (valid, controls, data, aluop = 5'b0).
- A capture with id_valid = 0 also writes valid = 0 and zeroes the controls.
- Forwarding (combinational, per source operand fwd_rs / fwd_rt):
  - index 0 is never forwarded; the registered value is used.
  - EX/MEM matches when exmem_regwrite & exmem_rd == index; this has priority.
  - Otherwise MEM/WB matches when memwb_regwrite & memwb_rd == index.
  - Otherwise the registered rs_val / rt_val is used.
- alu_a = asel_shamt ? {27'b0, shamt} : fwd_rs. The ALU's shift ops take the amount from A[4:0].
- alu_b = bsel_imm ? imm : fwd_rt.
- ex_store_data = fwd_rt, regardless of bsel_imm.
- Outputs ex_* mirror the registered fields directly.

## Timing
- Latency: ID inputs sampled at edge N appear on ex_*/alu_op after edge N. alu_a/alu_b settle combinationally in cycle N+1.
- stall is combinational in the same cycle as the hazard. Upstream holds ID, and exactly one bubble enters EX per load-use.
- After the bubble, the load sits in EX/MEM. It reaches MEM/WB the next cycle and is forwarded from MEM/WB, so no second stall occurs.
- Reset: after an rst edge all registered fields are 0, so ex_valid = ex_regwrite = ex_memread = ex_memwrite = ex_memtoreg = 0, ex_rd = 0, alu_op = 0. alu_a/alu_b then equal the forward-mux result over zeroed state.
- Reset mid-stall: rst wins; the stage is empty on the next cycle and stall drops unless hold_in = 1.
- flush and load_use together give a single bubble.
- hold_in with flush: the hold wins and the flush is lost. Upstream must re-assert flush when the hold releases.

## Test plan
- Reset: assert rst with nonzero id_* inputs for one edge → all ex_* = 0, alu_op = 0, stall = 0.
- EX/MEM priority: EX holds add with rs = 5, rs_val = 1; exmem writes r5 = 0x10, memwb writes r5 = 0x20 → alu_a = 0x10. Then drop exmem_regwrite → alu_a = 0x20.
- r0 guard: rs = 0, rs_val = 0, exmem_regwrite = 1, exmem_rd = 0, exmem_result = 0xFFFF → alu_a = 0.
- Load-use:
  - Setup: EX holds lw with rd = 8, ex_memread = 1; ID is add reading rt = 8 (id_uses_rt = 1).
  - Same cycle: stall = 1.
  - Next edge: ex_valid = 0 (bubble).
  - Following edge: add captured; with memwb r8 = 0x1234, alu_b = 0x1234.
- Shift/imm select: ID sll with shamt = 3, rt = 2 (rt_val 0x5), asel_shamt = 1, aluop = SLL → alu_a = 3, alu_b = 5. ID addi with imm = 0xFFFFFFFC, bsel_imm = 1 → alu_b = 0xFFFFFFFC; ex_store_data = forwarded rt.
- Flush/hold: flush with a valid ID → next ex_valid = 0. hold_in = 1 for 3 cycles with changing id_* → ex_* unchanged and stall = 1 throughout.
